// File: rtl/matmul_pkg.sv
// Types shared between the MatMul block driver and the tile writeback engine.
package matmul_pkg;

    localparam int TILE_DIM        = 8;
    localparam int TILE_DATA_WIDTH = 32;

    typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][TILE_DATA_WIDTH-1:0] tile_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

    function automatic int beats_per_row(input int bandwidth);
        return TILE_DIM / bandwidth;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Row/beat sequencing and element address generation for one tile writeback.
module tile_addr_gen
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 16,
    parameter int BANDWIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  dim_col,
    output logic [2:0]            row,
    output logic [2:0]            beat,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam int              BEATS     = beats_per_row(BANDWIDTH);
    localparam logic [2:0]      LAST_BEAT = 3'(BEATS - 1);
    localparam logic [2:0]      LAST_ROW  = 3'(TILE_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BANDWIDTH);

    logic [2:0]            row_r;
    logic [2:0]            beat_r;
    logic [ADDR_WIDTH-1:0] row_addr_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DIM_WIDTH-1:0]  dim_r;
    logic [ADDR_WIDTH-1:0] next_row_addr_s;

    // Row stride applied by addition; the sum wraps modulo the address width.
    assign next_row_addr_s = row_addr_r + ADDR_WIDTH'(dim_r);

    // Counter and address registers; addr_r always equals row_addr_r + beat_r*BANDWIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_r      <= 3'd0;
            beat_r     <= 3'd0;
            row_addr_r <= '0;
            addr_r     <= '0;
            dim_r      <= '0;
        end else if (load) begin
            row_r      <= 3'd0;
            beat_r     <= 3'd0;
            row_addr_r <= base_addr;
            addr_r     <= base_addr;
            dim_r      <= dim_col;
        end else if (advance) begin
            if (beat_r == LAST_BEAT) begin
                beat_r     <= 3'd0;
                row_r      <= row_r + 3'd1;
                row_addr_r <= next_row_addr_s;
                addr_r     <= next_row_addr_s;
            end else begin
                beat_r <= beat_r + 3'd1;
                addr_r <= addr_r + STEP;
            end
        end
    end

    assign row  = row_r;
    assign beat = beat_r;
    assign addr = addr_r;
    assign last = (row_r == LAST_ROW) && (beat_r == LAST_BEAT);

endmodule

// File: rtl/tile_writeback.sv
// Captures an 8x8 accumulator tile and streams it to result memory row by row,
// BANDWIDTH elements per beat, with registered request outputs.
module tile_writeback
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 16,
    parameter int BANDWIDTH  = 8
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] tile_in,
    input  logic [ADDR_WIDTH-1:0]                           base_addr,
    input  logic [DIM_WIDTH-1:0]                            dim_col,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            write,
    input  logic                                            write_rdy,
    output logic [ADDR_WIDTH-1:0]                           addr,
    output logic [BANDWIDTH*DATA_WIDTH-1:0]                 writedata
);

    localparam int BEATS       = beats_per_row(BANDWIDTH);
    localparam int CHUNKS      = TILE_DIM * BEATS;
    localparam int BEAT_SHIFT  = $clog2(BEATS);
    localparam int CHUNK_WIDTH = $clog2(CHUNKS);

    wb_state_t state_r;
    wb_state_t state_next_s;
    logic      load_s;
    logic      advance_s;
    logic      last_s;
    logic [2:0] row_s;
    logic [2:0] beat_s;

    // Tile viewed as consecutive write beats: beat j holds elements j*BANDWIDTH.. in row-major order.
    logic [CHUNKS-1:0][BANDWIDTH*DATA_WIDTH-1:0] tile_in_chunks_s;
    logic [CHUNKS-1:0][BANDWIDTH*DATA_WIDTH-1:0] tile_buf_r;
    logic [CHUNK_WIDTH-1:0]                      cur_chunk_s;
    logic [CHUNK_WIDTH-1:0]                      next_chunk_s;

    logic                            busy_r;
    logic                            done_r;
    logic                            write_r;
    logic [BANDWIDTH*DATA_WIDTH-1:0] writedata_r;

    assign tile_in_chunks_s = tile_in;
    assign cur_chunk_s      = (CHUNK_WIDTH'(row_s) << BEAT_SHIFT) | CHUNK_WIDTH'(beat_s);
    assign next_chunk_s     = cur_chunk_s + CHUNK_WIDTH'(1);

    tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .BANDWIDTH  (BANDWIDTH)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (load_s),
        .advance   (advance_s),
        .base_addr (base_addr),
        .dim_col   (dim_col),
        .row       (row_s),
        .beat      (beat_s),
        .addr      (addr),
        .last      (last_s)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state plus load/advance strobes; DONE accepts a new start like IDLE.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = WRITE;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (write_rdy) begin
                    advance_s = 1'b1;
                    if (last_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = WRITE;
                    end
                end else begin
                    state_next_s = WRITE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Registered outputs and tile buffer; writedata is preloaded with the beat that follows.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            write_r     <= 1'b0;
            writedata_r <= '0;
            tile_buf_r  <= '0;
        end else begin
            write_r <= (state_next_s == WRITE);
            busy_r  <= (state_next_s == WRITE);
            done_r  <= (state_next_s == DONE);
            if (load_s) begin
                tile_buf_r  <= tile_in_chunks_s;
                writedata_r <= tile_in_chunks_s[CHUNK_WIDTH'(0)];
            end else if (advance_s && !last_s) begin
                writedata_r <= tile_buf_r[next_chunk_s];
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign write     = write_r;
    assign writedata = writedata_r;

endmodule

// File: tb/tb_tile_writeback.sv
// Directed bench for tile_writeback at BANDWIDTH=8 and BANDWIDTH=2.
module tb_tile_writeback;
    import matmul_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int DMW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic           start8 = 1'b0;
    tile_t          tile8  = '0;
    logic [AW-1:0]  base8  = '0;
    logic [DMW-1:0] dim8   = '0;
    logic           rdy8   = 1'b1;
    logic           busy8, done8, write8;
    logic [AW-1:0]  addr8;
    logic [8*DW-1:0] wd8;

    logic           start2 = 1'b0;
    tile_t          tile2  = '0;
    logic [AW-1:0]  base2  = '0;
    logic [DMW-1:0] dim2   = '0;
    logic           rdy2   = 1'b1;
    logic           busy2, done2, write2;
    logic [AW-1:0]  addr2;
    logic [2*DW-1:0] wd2;

    tile_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW), .BANDWIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .tile_in(tile8), .base_addr(base8),
        .dim_col(dim8), .busy(busy8), .done(done8), .write(write8), .write_rdy(rdy8),
        .addr(addr8), .writedata(wd8)
    );

    tile_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW), .BANDWIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .tile_in(tile2), .base_addr(base2),
        .dim_col(dim2), .busy(busy2), .done(done2), .write(write2), .write_rdy(rdy2),
        .addr(addr2), .writedata(wd2)
    );

    typedef struct {
        logic [31:0] seed;
        logic [15:0] base;
        logic [15:0] dim;
        int          glitch;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] a7;
    } vec_t;

    vec_t            vecs[6];
    int              checks = 0;
    int              errors = 0;
    logic [AW-1:0]   got_addr[64];
    logic [8*DW-1:0] got_data[64];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic tile_t make_tile(input logic [31:0] seed);
        tile_t t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                t[r][c] = seed + 32'(r * 8 + c);
        return t;
    endfunction

    // Samples 20 cycles from the current point; cycle 1 is the first cycle after start.
    task automatic collect8(input int glitch, output int nbeats, output int done_cyc, output int done_cnt);
        nbeats = 0; done_cyc = -1; done_cnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (write8 && rdy8) begin
                if (nbeats < 64) begin
                    got_addr[nbeats] = addr8;
                    got_data[nbeats] = wd8;
                end
                nbeats++;
            end
            if (done8) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == glitch) begin
                start8 = 1'b1;
                tile8  = make_tile(32'hAAAA_0000);
                base8  = 16'h0500;
                dim8   = 16'd4;
            end else begin
                start8 = 1'b0;
            end
            tick();
        end
    endtask

    task automatic run8(input logic [31:0] seed, input logic [15:0] base, input logic [15:0] dim,
                        input int glitch, output int nbeats, output int done_cyc, output int done_cnt);
        tile8 = make_tile(seed); base8 = base; dim8 = dim; rdy8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        collect8(glitch, nbeats, done_cyc, done_cnt);
    endtask

    initial begin
        int    n, dc, dn, k, n2;
        tile_t exp_t;
        logic  stalled;
        logic [AW-1:0]   sa;
        logic [2*DW-1:0] sd;
        logic [AW-1:0]   a2[32];

        vecs[0] = '{32'h0000_0000, 16'h0100, 16'd16, 0, 16'h0100, 16'h0110, 16'h0170};
        vecs[1] = '{32'h1000_0000, 16'hFFF8, 16'd8,  0, 16'hFFF8, 16'h0000, 16'h0030};
        vecs[2] = '{32'h0000_0040, 16'h0200, 16'd0,  0, 16'h0200, 16'h0200, 16'h0200};
        vecs[3] = '{32'h00C0_0000, 16'h0040, 16'd4,  0, 16'h0040, 16'h0044, 16'h005C};
        vecs[4] = '{32'h5555_0000, 16'h1234, 16'h0100, 0, 16'h1234, 16'h1334, 16'h1934};
        vecs[5] = '{32'h0000_0100, 16'h0300, 16'd16, 3, 16'h0300, 16'h0310, 16'h0370};

        repeat (2) tick();
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_write8", write8, 1'b0);
        check("rst_addr8", addr8, 16'h0000);
        check("rst_data8", wd8, '0);
        check("rst_write2", write2, 1'b0);
        check("rst_addr2", addr2, 16'h0000);
        check("rst_data2", wd2, '0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run8(vecs[i].seed, vecs[i].base, vecs[i].dim, vecs[i].glitch, n, dc, dn);
            check($sformatf("v%0d_beats", i), n, 8);
            check($sformatf("v%0d_done_cycle", i), dc, 9);
            check($sformatf("v%0d_done_count", i), dn, 1);
            check($sformatf("v%0d_addr0", i), got_addr[0], vecs[i].a0);
            check($sformatf("v%0d_addr1", i), got_addr[1], vecs[i].a1);
            check($sformatf("v%0d_addr7", i), got_addr[7], vecs[i].a7);
            exp_t = make_tile(vecs[i].seed);
            for (int r = 0; r < 8; r++) begin
                check($sformatf("v%0d_row%0d_addr", i, r), got_addr[r],
                      16'(vecs[i].base + 16'(r) * vecs[i].dim));
                check($sformatf("v%0d_row%0d_data", i, r), got_data[r], exp_t[r]);
            end
        end

        // Back-to-back tiles: second start lands in the DONE cycle.
        tile8 = make_tile(32'h0); base8 = 16'h0100; dim8 = 16'd16; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("b2b_busy", busy8, 1'b1);
        k = 0;
        while (!done8 && k < 20) begin
            tick();
            k++;
        end
        check("b2b_first_done_seen", done8, 1'b1);
        check("b2b_first_done_cycle", k, 8);
        tile8 = '1; base8 = 16'h0800; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("b2b_done_single", done8, 1'b0);
        check("b2b_write_next", write8, 1'b1);
        check("b2b_addr_next", addr8, 16'h0800);
        check("b2b_data_next", wd8, {8{32'hFFFF_FFFF}});
        collect8(0, n, dc, dn);
        check("b2b_beats", n, 8);
        check("b2b_done_cycle", dc, 9);
        check("b2b_done_count", dn, 1);
        check("b2b_addr7", got_addr[7], 16'h0870);
        check("b2b_data7", got_data[7], {8{32'hFFFF_FFFF}});

        // Asynchronous reset in the middle of a tile.
        tile8 = make_tile(32'h0); base8 = 16'h0100; dim8 = 16'd16; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        check("rst_mid_pre_write", write8, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_write", write8, 1'b0);
        check("rst_mid_busy", busy8, 1'b0);
        check("rst_mid_addr", addr8, 16'h0000);
        check("rst_mid_data", wd8, '0);
        tick();
        reset = 1'b0;
        dn = 0;
        repeat (12) begin
            if (done8 || write8) dn++;
            tick();
        end
        check("rst_mid_no_activity", dn, 0);
        run8(32'h5, 16'h0100, 16'd16, 0, n, dc, dn);
        check("rst_after_beats", n, 8);
        check("rst_after_done_cycle", dc, 9);
        exp_t = make_tile(32'h5);
        check("rst_after_addr7", got_addr[7], 16'h0170);
        check("rst_after_data7", got_data[7], exp_t[7]);

        // BANDWIDTH=2 with write_rdy low every third cycle.
        tile2 = make_tile(32'h0); base2 = 16'h0100; dim2 = 16'd16; rdy2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        exp_t = make_tile(32'h0);
        n2 = 0; dn = 0; stalled = 1'b0; sa = '0; sd = '0;
        for (int cyc = 1; cyc <= 80 && dn == 0; cyc++) begin
            rdy2 = (cyc % 3 != 0);
            if (stalled) begin
                check("bw2_stall_write", write2, 1'b1);
                check("bw2_stall_addr", addr2, sa);
                check("bw2_stall_data", wd2, sd);
            end
            stalled = write2 && !rdy2;
            sa = addr2;
            sd = wd2;
            if (write2 && rdy2) begin
                if (n2 < 32) begin
                    a2[n2] = addr2;
                    check($sformatf("bw2_beat%0d_addr", n2), addr2,
                          16'(16'h0100 + (n2 / 4) * 16 + (n2 % 4) * 2));
                    check($sformatf("bw2_beat%0d_data", n2), wd2,
                          {exp_t[n2 / 4][(n2 % 4) * 2 + 1], exp_t[n2 / 4][(n2 % 4) * 2]});
                end
                n2++;
            end
            if (done2) dn++;
            tick();
        end
        rdy2 = 1'b1;
        check("bw2_beats", n2, 32);
        check("bw2_done_seen", dn, 1);
        check("bw2_done_pulse_ends", done2, 1'b0);
        check("bw2_addr3", a2[3], 16'h0106);
        check("bw2_addr4", a2[4], 16'h0110);
        check("bw2_addr31", a2[31], 16'h0176);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
